// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one sram-like memory port between the core's inst and data sram
//   interfaces. Address phase uses req/addr_ok and response phase uses
//   data_ok/rdata. The downstream slave answers strictly in issue order, so a
//   small owner FIFO records who issued each accepted request. Each response
//   is then routed back to the requester that owns it.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   inst_sram_*          inst requester: req/wr/size/wstrb/addr/wdata in,
//                        addr_ok/data_ok/rdata out
//   data_sram_*          data requester, same set of signals as inst
//   mem_*                shared downstream port: req/wr/size/wstrb/addr/wdata
//                        out, addr_ok/data_ok/rdata in
//   outst_cnt            number of accepted requests still waiting for data_ok
//   err_spurious         sticky flag: mem_data_ok arrived with no request outstanding
module sram_bus_arbiter #(
  parameter int unsigned OUTST_DEPTH = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             inst_sram_req,
  input  logic             inst_sram_wr,
  input  logic [1:0]       inst_sram_size,
  input  logic [3:0]       inst_sram_wstrb,
  input  logic [31:0]      inst_sram_addr,
  input  logic [31:0]      inst_sram_wdata,
  output logic             inst_sram_addr_ok,
  output logic             inst_sram_data_ok,
  output logic [31:0]      inst_sram_rdata,

  input  logic             data_sram_req,
  input  logic             data_sram_wr,
  input  logic [1:0]       data_sram_size,
  input  logic [3:0]       data_sram_wstrb,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic             data_sram_addr_ok,
  output logic             data_sram_data_ok,
  output logic [31:0]      data_sram_rdata,

  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,

  output logic [CNT_W-1:0] outst_cnt,
  output logic             err_spurious
);

  localparam int unsigned PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

  // The lock flag and lock owner are folded into one state. ARB_FREE means
  // no lock is held. The two HOLD states pin the grant to one requester until
  // the slave accepts that requester's pending request.
  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_HOLD_INST,
    ARB_HOLD_DATA
  } arb_state_e;

  arb_state_e             state_q, state_d;
  logic [OUTST_DEPTH-1:0] owner_q, owner_d;   // 1 = data, 0 = inst
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic grant_data;
  logic granted_req;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_owner;

  // Grant selection and datapath mux
  always_comb begin
    unique case (state_q)
      ARB_HOLD_INST: grant_data = 1'b0;
      ARB_HOLD_DATA: grant_data = 1'b1;
      default:       grant_data = data_sram_req;
    endcase

    granted_req = grant_data ? data_sram_req : inst_sram_req;
    full        = (cnt_q == CNT_W'(OUTST_DEPTH));
    empty       = (cnt_q == '0);

    // full is taken from the registered count. A pop in the same cycle
    // therefore does not reopen issue until the next cycle. This also keeps
    // any combinational path from mem_data_ok to mem_req out of the design.
    mem_req   = granted_req & ~full & ~reset;
    mem_wr    = grant_data ? data_sram_wr    : inst_sram_wr;
    mem_size  = grant_data ? data_sram_size  : inst_sram_size;
    mem_wstrb = grant_data ? data_sram_wstrb : inst_sram_wstrb;
    mem_addr  = grant_data ? data_sram_addr  : inst_sram_addr;
    mem_wdata = grant_data ? data_sram_wdata : inst_sram_wdata;

    push = mem_req & mem_addr_ok;
    pop  = mem_data_ok & ~empty & ~reset;

    head_owner = owner_q[head_q];

    inst_sram_addr_ok = push & ~grant_data;
    data_sram_addr_ok = push &  grant_data;
    inst_sram_data_ok = pop  & ~head_owner;
    data_sram_data_ok = pop  &  head_owner;

    inst_sram_rdata = mem_rdata;
    data_sram_rdata = mem_rdata;

    outst_cnt    = cnt_q;
    err_spurious = err_q;
  end

  // Next-state: lock tracking, owner FIFO, outstanding count, error flag
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (push) begin
      state_d = ARB_FREE;
    end else if (mem_req) begin
      state_d = grant_data ? ARB_HOLD_DATA : ARB_HOLD_INST;
    end

    if (push) begin
      owner_d[tail_q] = grant_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (mem_data_ok && empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_FREE;
      owner_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outst_cnt;
  logic        err_spurious;

  sram_bus_arbiter #(.OUTST_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outst_cnt(outst_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of owners in issue order (1 = data), pending request owner, sticky error
  bit m_own[$];
  bit m_pend;
  bit m_pend_data;
  bit m_err;

  // Values observed during the most recent step, used by the directed checks
  logic        obs_req, obs_iaok, obs_daok, obs_idok, obs_ddok, obs_err;
  logic [31:0] obs_addr, obs_irdata, obs_drdata;
  logic [2:0]  obs_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_own.delete();
    m_pend = 1'b0;
    m_pend_data = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Starts 1 time unit after a rising edge and returns 1 time unit after the next one.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                      input bit aok, input bit dok, input logic [31:0] rd);
    logic        iw, dw, g_data, g_req, e_req, acc, e_pop, e_head, spur;
    logic [1:0]  isz, dsz;
    logic [3:0]  ist, dst;
    logic [31:0] iwd, dwd;
    iw = 1'($urandom);           dw = 1'($urandom);
    isz = 2'($urandom);          dsz = 2'($urandom);
    ist = 4'($urandom);          dst = 4'($urandom);
    iwd = $urandom;              dwd = $urandom;
    inst_sram_req = ir; inst_sram_addr = ia; inst_sram_wr = iw; inst_sram_size = isz;
    inst_sram_wstrb = ist; inst_sram_wdata = iwd;
    data_sram_req = dr; data_sram_addr = da; data_sram_wr = dw; data_sram_size = dsz;
    data_sram_wstrb = dst; data_sram_wdata = dwd;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    #2;
    g_data = m_pend ? m_pend_data : dr;
    g_req  = g_data ? dr : ir;
    e_req  = g_req && (m_own.size() < DEPTH);
    acc    = e_req && aok;
    e_pop  = dok && (m_own.size() > 0);
    e_head = (m_own.size() > 0) ? m_own[0] : 1'b0;
    spur   = dok && (m_own.size() == 0);

    check_eq("mem_req", 64'(mem_req), 64'(e_req));
    check_eq("mem_addr", 64'(mem_addr), 64'(g_data ? da : ia));
    check_eq("mem_wdata", 64'(mem_wdata), 64'(g_data ? dwd : iwd));
    check_eq("mem_ctl", 64'({mem_wr, mem_size, mem_wstrb}),
             64'(g_data ? {dw, dsz, dst} : {iw, isz, ist}));
    check_eq("inst_addr_ok", 64'(inst_sram_addr_ok), 64'(acc && !g_data));
    check_eq("data_addr_ok", 64'(data_sram_addr_ok), 64'(acc && g_data));
    check_eq("inst_data_ok", 64'(inst_sram_data_ok), 64'(e_pop && !e_head));
    check_eq("data_data_ok", 64'(data_sram_data_ok), 64'(e_pop && e_head));
    check_eq("inst_rdata", 64'(inst_sram_rdata), 64'(rd));
    check_eq("data_rdata", 64'(data_sram_rdata), 64'(rd));
    check_eq("outst_cnt", 64'(outst_cnt), 64'(m_own.size()));
    check_eq("err_spurious", 64'(err_spurious), 64'(m_err));

    obs_req = mem_req; obs_iaok = inst_sram_addr_ok; obs_daok = data_sram_addr_ok;
    obs_idok = inst_sram_data_ok; obs_ddok = data_sram_data_ok; obs_err = err_spurious;
    obs_addr = mem_addr; obs_irdata = inst_sram_rdata; obs_drdata = data_sram_rdata;
    obs_cnt = outst_cnt;

    if (e_pop) void'(m_own.pop_front());
    if (acc) m_own.push_back(g_data);
    if (spur) m_err = 1'b1;
    if (acc) m_pend = 1'b0;
    else if (e_req) begin
      m_pend = 1'b1;
      m_pend_data = g_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_cnt", 64'(outst_cnt), 64'd0);
    check_eq("rst_err", 64'(err_spurious), 64'd0);
    check_eq("rst_ok", 64'({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h8000_1234;

  bit          ihold, dhold, ir, dr, aok, dok;
  logic [31:0] ia_h, da_h, ia, da;

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Both request together: data wins first, then inst
    step(1, IA, 1, DA, 1, 0, 0);
    check_eq("t1_c0_addr", 64'(obs_addr), 64'(DA));
    check_eq("t1_c0_daok", 64'(obs_daok), 64'd1);
    step(1, IA, 0, 0, 1, 0, 0);
    check_eq("t1_c1_iaok", 64'(obs_iaok), 64'd1);
    check_eq("t1_c1_cnt", 64'(obs_cnt), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("t1_c2_cnt", 64'(obs_cnt), 64'd2);

    // A pending inst request holds the port even after data_req rises
    do_reset();
    step(1, IA, 0, 0, 0, 0, 0);
    step(1, IA, 1, DA, 0, 0, 0);
    check_eq("t2_hold1", 64'(obs_addr), 64'(IA));
    step(1, IA, 1, DA, 0, 0, 0);
    check_eq("t2_hold2", 64'(obs_addr), 64'(IA));
    step(1, IA, 1, DA, 1, 0, 0);
    check_eq("t2_accept_inst", 64'(obs_iaok), 64'd1);
    step(0, 0, 1, DA, 1, 0, 0);
    check_eq("t2_data_addr", 64'(obs_addr), 64'(DA));
    check_eq("t2_data_aok", 64'(obs_daok), 64'd1);

    // Full FIFO blocks issue; a pop reopens it only on the following cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, IA + 32'(i * 4), 0, 0, 1, 0, 0);
    step(1, IA + 32'h40, 0, 0, 1, 0, 0);
    check_eq("t3_full_req", 64'(obs_req), 64'd0);
    check_eq("t3_full_cnt", 64'(obs_cnt), 64'(DEPTH));
    step(1, IA + 32'h40, 0, 0, 1, 1, 32'h5);
    check_eq("t3_pop_same_cycle_req", 64'(obs_req), 64'd0);
    step(1, IA + 32'h40, 0, 0, 1, 0, 0);
    check_eq("t3_resume_req", 64'(obs_req), 64'd1);
    check_eq("t3_resume_cnt", 64'(obs_cnt), 64'(DEPTH - 1));

    // Responses are routed in issue order: I, D, I
    do_reset();
    step(1, IA, 0, 0, 1, 0, 0);
    step(0, 0, 1, DA, 1, 0, 0);
    step(1, IA + 4, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h11);
    check_eq("t4_r0_idok", 64'({obs_idok, obs_ddok}), 64'b10);
    check_eq("t4_r0_data", 64'(obs_irdata), 64'h11);
    step(0, 0, 0, 0, 0, 1, 32'h22);
    check_eq("t4_r1_ddok", 64'({obs_idok, obs_ddok}), 64'b01);
    check_eq("t4_r1_data", 64'(obs_drdata), 64'h22);
    step(0, 0, 0, 0, 0, 1, 32'h33);
    check_eq("t4_r2_idok", 64'({obs_idok, obs_ddok}), 64'b10);
    check_eq("t4_r2_data", 64'(obs_irdata), 64'h33);

    // A response with nothing outstanding sets a sticky error flag
    do_reset();
    step(0, 0, 0, 0, 0, 1, 32'hdead);
    check_eq("t5_no_dok", 64'({obs_idok, obs_ddok}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check_eq("t5_sticky", 64'(obs_err), 64'd1);
    end

    // Asserting reset mid-transaction drops lock and outstanding state at once
    do_reset();
    step(1, IA, 0, 0, 1, 0, 0);
    step(1, IA + 4, 0, 0, 1, 0, 0);
    step(1, IA + 8, 1, DA, 0, 0, 0);
    check_eq("t6_cnt_pre", 64'(outst_cnt), 64'd2);
    inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    reset = 1'b1;
    #2;
    check_eq("t6_rst_req", 64'(mem_req), 64'd0);
    check_eq("t6_rst_cnt", 64'(outst_cnt), 64'd0);
    check_eq("t6_rst_ok", 64'({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}), 64'd0);
    model_clear();
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, IA, 1, DA, 1, 0, 0);
    check_eq("t6_fresh_addr", 64'(obs_addr), 64'(DA));
    check_eq("t6_fresh_daok", 64'(obs_daok), 64'd1);

    // Random traffic; requesters hold req and addr until accepted
    do_reset();
    ihold = 0; dhold = 0; ia_h = 0; da_h = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        do_reset();
        ihold = 0;
        dhold = 0;
      end
      ir  = ihold ? 1'b1 : 1'($urandom);
      ia  = ihold ? ia_h : $urandom;
      dr  = dhold ? 1'b1 : 1'($urandom);
      da  = dhold ? da_h : $urandom;
      aok = ($urandom_range(0, 9) < 6);
      dok = (m_own.size() > 0) && 1'($urandom);
      step(ir, ia, dr, da, aok, dok, $urandom);
      ihold = ir && !obs_iaok;
      dhold = dr && !obs_daok;
      ia_h = ia;
      da_h = da;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
